serial_adder_ctrl: RTL

- Bit-serial adder controller that reuses one full-adder cell to add two WIDTH-bit operands over WIDTH clock cycles.
- It sequences the cell LSB-first, holding the running carry in a register.
- It sits between a requester (start/done handshake) and the single-bit adder datapath, trading latency for area.

---
 rtl/serial_adder_pkg.sv | 28 ++
 rtl/fa_cell.sv | 23 ++
 rtl/serial_adder_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
//==============================================================================
// Module      : serial_adder_pkg
// Description : Shared types and constants for the bit-serial adder controller
//               (state encoding, default operand width, counter width helper).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package serial_adder_pkg;

  // Default operand/sum width
  localparam int unsigned c_DEFAULT_WIDTH = 8;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fa_cell.sv
//==============================================================================
// Module      : fa_cell
// Description : Purely combinational 1-bit full adder, the single arithmetic
//               cell reused on every cycle by the serial adder controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic so,
  output logic co
);

  // Sum and majority carry
  assign so = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
//==============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder controller. Adds two WIDTH-bit operands plus
//               carry-in over WIDTH cycles, LSB first, through one fa_cell.
//               Optional macro SERIAL_ADD_OVF_EN adds the signed overflow
//               output ovf.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = c_DEFAULT_WIDTH,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] so,
  output logic             co
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_so;
  logic             r_carry;
  logic             r_co;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_c;
  logic             w_last;

  // The one shared full-adder cell, fed from the operand LSBs
  fa_cell u_fa_cell (
    .a  (r_sa[0]),
    .b  (r_sb[0]),
    .ci (r_carry),
    .so (w_s),
    .co (w_c)
  );

  // Current edge handles the operand MSB
  assign w_last = (r_cnt == c_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, LSB-first shifting, carry chain and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_so    <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_sa    <= a;
          r_sb    <= b;
          r_carry <= ci;
          r_cnt   <= '0;
          r_so    <= '0;
          r_co    <= 1'b0;
        end
        RUN: begin
          r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
          r_so    <= {w_s, r_so[WIDTH-1:1]};
          r_carry <= w_c;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) r_co <= w_c;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB (carry register) versus carry out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= r_carry ^ w_c;
    end
  end

  assign ovf = r_ovf;
`endif

  assign so = r_so;
  assign co = r_co;

endmodule

`default_nettype wire
